// File: rtl/multsigned_pkg.sv
// multsigned_pkg: shared saturation limits and round/shift helper for the multsigned datapath
package multsigned_pkg;
  typedef logic signed [63:0] wide_t;
  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction
  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction
  // Round-half-up arithmetic right shift; s == 0 passes the value through.
  function automatic wide_t round_shift(input wide_t v, input int s);
    return (s == 0) ? v : (v + (wide_t'(1) <<< (s - 1))) >>> s;
  endfunction
endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one-entry valid/ready register slice
//   clk_i, rst_i        clock, sync active-high reset
//   valid_i/ready_o     upstream handshake, data_i payload
//   valid_o/ready_i     downstream handshake, data_o registered payload
module pipe_stage #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o
);
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  assign ready_o = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  always_comb begin
    valid_d = ready_o ? valid_i : valid_q;
    data_d  = (ready_o && valid_i) ? data_i : data_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/saturating_narrower.sv
// saturating_narrower: two-stage signed narrowing (round/shift, then saturate) with saturation counter
//   clk_i, rst_i              clock, sync active-high reset
//   in_valid_i/in_ready_o     input handshake; in_i value, shift_i right-shift amount
//   out_valid_o/out_ready_i   output handshake; out_o narrowed value, sat_o clamped flag
//   clr_cnt_i, sat_cnt_o      clear and value of the sticky saturation counter
module saturating_narrower
  import multsigned_pkg::*;
#(
  parameter int IN_SIZE  = 8,
  parameter int OUT_SIZE = 4,
  parameter int SHIFT_W  = $clog2(IN_SIZE),
  parameter int CNT_W    = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic signed [IN_SIZE-1:0]  in_i,
  input  logic        [SHIFT_W-1:0]  shift_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic signed [OUT_SIZE-1:0] out_o,
  output logic                       sat_o,
  input  logic                       clr_cnt_i,
  output logic        [CNT_W-1:0]    sat_cnt_o
);
  localparam logic signed [OUT_SIZE-1:0] MAX_V = OUT_SIZE'(sat_max(OUT_SIZE));
  localparam logic signed [OUT_SIZE-1:0] MIN_V = OUT_SIZE'(sat_min(OUT_SIZE));
  logic              s1_ready, s1_valid, s2_ready;
  logic [IN_SIZE:0]  r_d, s1_r;
  logic [OUT_SIZE:0] s2_d, s2_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  int                shamt;
  assign in_ready_o = s1_ready && !rst_i;
  assign out_o      = s2_q[OUT_SIZE:1];
  assign sat_o      = s2_q[0];
  assign sat_cnt_o  = cnt_q;
  always_comb begin
    shamt = (int'(shift_i) > IN_SIZE - 1) ? IN_SIZE - 1 : int'(shift_i);
    r_d   = (IN_SIZE + 1)'(round_shift(wide_t'(in_i), shamt));
    s2_d  = ($signed(s1_r) > sat_max(OUT_SIZE)) ? {MAX_V, 1'b1} :
            ($signed(s1_r) < sat_min(OUT_SIZE)) ? {MIN_V, 1'b1} :
            {s1_r[OUT_SIZE-1:0], 1'b0};
    cnt_d = clr_cnt_i ? '0 :
            (out_valid_o && out_ready_i && sat_o && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  pipe_stage #(.WIDTH(IN_SIZE + 1)) u_s1 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (in_valid_i),
    .ready_o (s1_ready),
    .data_i  (r_d),
    .valid_o (s1_valid),
    .ready_i (s2_ready),
    .data_o  (s1_r)
  );
  pipe_stage #(.WIDTH(OUT_SIZE + 1)) u_s2 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (s1_valid),
    .ready_o (s2_ready),
    .data_i  (s2_d),
    .valid_o (out_valid_o),
    .ready_i (out_ready_i),
    .data_o  (s2_q)
  );
endmodule
